// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: function codes and PC step.
package branch_pkg;

    typedef enum logic [3:0] {
        BF_BLTZ = 4'b0000,
        BF_BGEZ = 4'b0001,
        BF_BEQ  = 4'b0010,
        BF_BNE  = 4'b0011,
        BF_BLEZ = 4'b0100,
        BF_BGTZ = 4'b0101,
        BF_JMP  = 4'b0110
    } bf_t;

    localparam logic [3:0]  BF_ILLEGAL_MIN = 4'b0111;
    localparam int unsigned PC_STEP        = 4;

endpackage

// File: rtl/branch_redirect_if.sv
// Branch-op input channel, resolved-result output channel, redirect and statistics.
interface branch_redirect_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_pc;
    logic [W-1:0]     in_imm;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [3:0]       in_bf;
    logic             in_pred;

    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_mispred;
    logic             out_illegal;
    logic [W-1:0]     out_npc;

    logic             redirect_valid;
    logic [W-1:0]     redirect_pc;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    modport slave (
        input  in_valid, in_pc, in_imm, in_a, in_b, in_bf, in_pred, out_ready,
        output in_ready, out_valid, out_taken, out_mispred, out_illegal, out_npc,
               redirect_valid, redirect_pc, br_cnt, mis_cnt
    );

    modport master (
        output in_valid, in_pc, in_imm, in_a, in_b, in_bf, in_pred, out_ready,
        input  in_ready, out_valid, out_taken, out_mispred, out_illegal, out_npc,
               redirect_valid, redirect_pc, br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_redirect_bcond_eval.sv
// Combinational branch-condition evaluator; operands are two's-complement signed.
module bcond_eval
    import branch_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   bf,
    output logic         taken,
    output logic         illegal
);
    logic a_neg_s;
    logic a_zero_s;

    assign a_neg_s  = a[W-1];
    assign a_zero_s = (a == {W{1'b0}});

    // Decode the function code into a direction; unknown codes resolve not-taken
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (bf)
            BF_BLTZ: taken = a_neg_s;
            BF_BGEZ: taken = !a_neg_s;
            BF_BEQ:  taken = (a == b);
            BF_BNE:  taken = (a != b);
            BF_BLEZ: taken = a_neg_s || a_zero_s;
            BF_BGTZ: taken = !a_neg_s && !a_zero_s;
            BF_JMP:  taken = 1'b1;
            default: illegal = (bf >= BF_ILLEGAL_MIN);
        endcase
    end
endmodule

// File: rtl/branch_redirect.sv
// Two-stage branch resolution: S1 captures the op, S2 holds the evaluated result;
// a mispredicted retire squashes the younger op and pulses a fetch redirect.
module branch_redirect
    import branch_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_redirect_if.slave bus
);
    localparam logic [W-1:0]     PC_STEP_W = W'(PC_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_pc_q,    s1_pc_d;
    logic [W-1:0]     s1_imm_q,   s1_imm_d;
    logic [W-1:0]     s1_a_q,     s1_a_d;
    logic [W-1:0]     s1_b_q,     s1_b_d;
    logic [3:0]       s1_bf_q,    s1_bf_d;
    logic             s1_pred_q,  s1_pred_d;

    logic             s2_valid_q,   s2_valid_d;
    logic             s2_taken_q,   s2_taken_d;
    logic             s2_mispred_q, s2_mispred_d;
    logic             s2_illegal_q, s2_illegal_d;
    logic [W-1:0]     s2_npc_q,     s2_npc_d;

    logic             redir_valid_q, redir_valid_d;
    logic [W-1:0]     redir_pc_q,    redir_pc_d;
    logic [CNT_W-1:0] br_cnt_q,      br_cnt_d;
    logic [CNT_W-1:0] mis_cnt_q,     mis_cnt_d;

    logic             advance_s, retire_s, squash_s, in_ready_s, accept_s;
    logic             eval_taken_s, eval_illegal_s;
    logic [W-1:0]     fall_s, target_s;

    assign advance_s  = !s2_valid_q || bus.out_ready;
    assign retire_s   = s2_valid_q && bus.out_ready;
    assign squash_s   = retire_s && s2_mispred_q;
    assign in_ready_s = !s1_valid_q || advance_s;
    assign accept_s   = bus.in_valid && in_ready_s;

    bcond_eval #(.W(W)) u_eval (
        .a       (s1_a_q),
        .b       (s1_b_q),
        .bf      (s1_bf_q),
        .taken   (eval_taken_s),
        .illegal (eval_illegal_s)
    );

    assign fall_s   = s1_pc_q + PC_STEP_W;
    assign target_s = fall_s + (s1_imm_q << 2'd2);

    // S1 capture; a squash drops both the held op and anything arriving this cycle
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_pc_d    = s1_pc_q;
        s1_imm_d   = s1_imm_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_bf_d    = s1_bf_q;
        s1_pred_d  = s1_pred_q;
        if (squash_s) begin
            s1_valid_d = 1'b0;
        end else if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_pc_d    = bus.in_pc;
            s1_imm_d   = bus.in_imm;
            s1_a_d     = bus.in_a;
            s1_b_d     = bus.in_b;
            s1_bf_d    = bus.in_bf;
            s1_pred_d  = bus.in_pred;
        end else if (advance_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 result; data only changes on a real load so a stalled output is stable
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_taken_d   = s2_taken_q;
        s2_mispred_d = s2_mispred_q;
        s2_illegal_d = s2_illegal_q;
        s2_npc_d     = s2_npc_q;
        if (advance_s) begin
            if (s1_valid_q && !squash_s) begin
                s2_valid_d   = 1'b1;
                s2_taken_d   = eval_taken_s;
                s2_mispred_d = eval_taken_s ^ s1_pred_q;
                s2_illegal_d = eval_illegal_s;
                s2_npc_d     = eval_taken_s ? target_s : fall_s;
            end else begin
                s2_valid_d   = 1'b0;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Redirect pulse and retire statistics
    always_comb begin
        redir_valid_d = squash_s;
        redir_pc_d    = squash_s ? s2_npc_q : redir_pc_q;
        br_cnt_d      = retire_s ? (br_cnt_q + CNT_ONE) : br_cnt_q;
        mis_cnt_d     = squash_s ? (mis_cnt_q + CNT_ONE) : mis_cnt_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_pc_q       <= {W{1'b0}};
            s1_imm_q      <= {W{1'b0}};
            s1_a_q        <= {W{1'b0}};
            s1_b_q        <= {W{1'b0}};
            s1_bf_q       <= 4'b0000;
            s1_pred_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_taken_q    <= 1'b0;
            s2_mispred_q  <= 1'b0;
            s2_illegal_q  <= 1'b0;
            s2_npc_q      <= {W{1'b0}};
            redir_valid_q <= 1'b0;
            redir_pc_q    <= {W{1'b0}};
            br_cnt_q      <= {CNT_W{1'b0}};
            mis_cnt_q     <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_pc_q       <= s1_pc_d;
            s1_imm_q      <= s1_imm_d;
            s1_a_q        <= s1_a_d;
            s1_b_q        <= s1_b_d;
            s1_bf_q       <= s1_bf_d;
            s1_pred_q     <= s1_pred_d;
            s2_valid_q    <= s2_valid_d;
            s2_taken_q    <= s2_taken_d;
            s2_mispred_q  <= s2_mispred_d;
            s2_illegal_q  <= s2_illegal_d;
            s2_npc_q      <= s2_npc_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            br_cnt_q      <= br_cnt_d;
            mis_cnt_q     <= mis_cnt_d;
        end
    end

    assign bus.in_ready       = in_ready_s;
    assign bus.out_valid      = s2_valid_q;
    assign bus.out_taken      = s2_taken_q;
    assign bus.out_mispred    = s2_mispred_q;
    assign bus.out_illegal    = s2_illegal_q;
    assign bus.out_npc        = s2_npc_q;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.br_cnt         = br_cnt_q;
    assign bus.mis_cnt        = mis_cnt_q;
endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: transaction-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_redirect;
    import branch_pkg::*;

    localparam int W     = 32;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_redirect_if #(.W(W), .CNT_W(CNT_W)) bus ();
    branch_redirect #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] npc;
        logic        taken;
        logic        illegal;
        logic        mis;
        int          acc;
    } ent_t;

    // In-flight (accepted, not yet retired) ops in program order
    ent_t        q[$];
    int          m_e    = 0;
    logic        m_rv   = 1'b0;
    logic [31:0] m_rpc  = 32'd0;
    logic [15:0] m_br   = 16'd0;
    logic [15:0] m_mis  = 16'd0;
    logic        m_live = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic ent_t ref_eval(input logic [31:0] pc, input logic [31:0] imm,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] bf, input logic pred);
        ent_t r;
        int   sa, sb;
        logic t;
        sa = a;
        sb = b;
        case (bf)
            4'd0:    t = (sa < 0);
            4'd1:    t = (sa >= 0);
            4'd2:    t = (sa == sb);
            4'd3:    t = (sa != sb);
            4'd4:    t = (sa <= 0);
            4'd5:    t = (sa > 0);
            4'd6:    t = 1'b1;
            default: t = 1'b0;
        endcase
        r.taken   = t;
        r.illegal = (bf >= 4'd7);
        r.npc     = t ? (pc + 32'd4 + imm * 32'd4) : (pc + 32'd4);
        r.mis     = t ^ pred;
        r.acc     = 0;
        return r;
    endfunction

    task automatic model_loop();
        ent_t h, n;
        logic ov, ac, sq;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                m_e = 0; m_rv = 1'b0; m_rpc = 32'd0; m_br = 16'd0; m_mis = 16'd0; m_live = 1'b0;
            end else begin
                ov   = (q.size() > 0) && (q[0].acc < m_e);
                ac   = bus.in_valid && ((q.size() < 2) || bus.out_ready);
                sq   = 1'b0;
                m_rv = 1'b0;
                if (ov && bus.out_ready) begin
                    h    = q.pop_front();
                    m_br = m_br + 16'd1;
                    if (h.mis) begin
                        m_mis = m_mis + 16'd1;
                        m_rv  = 1'b1;
                        m_rpc = h.npc;
                        sq    = 1'b1;
                        q.delete();
                    end
                end
                m_e++;
                if (ac && !sq) begin
                    n = ref_eval(bus.in_pc, bus.in_imm, bus.in_a, bus.in_b, bus.in_bf, bus.in_pred);
                    n.acc = m_e;
                    q.push_back(n);
                end
                m_live = 1'b1;
            end
        end
    endtask

    task automatic compare_loop();
        logic ov;
        forever begin
            @(negedge clk);
            if (rst_n && m_live) begin
                ov = (q.size() > 0) && (q[0].acc < m_e);
                chk("out_valid", bus.out_valid, ov);
                chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
                if (ov) begin
                    chk("out_npc", bus.out_npc, q[0].npc);
                    chk("out_taken", bus.out_taken, q[0].taken);
                    chk("out_mispred", bus.out_mispred, q[0].mis);
                    chk("out_illegal", bus.out_illegal, q[0].illegal);
                end
                chk("redirect_valid", bus.redirect_valid, m_rv);
                chk("redirect_pc", bus.redirect_pc, m_rpc);
                chk("br_cnt", bus.br_cnt, m_br);
                chk("mis_cnt", bus.mis_cnt, m_mis);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] bf, input logic pred);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_imm   = imm;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_bf    = bf;
        bus.in_pred  = pred;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom % 5)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        ent_t        e;
        logic [31:0] ra;
        bus.in_valid  = 1'b0;
        bus.in_pc     = 32'd0;
        bus.in_imm    = 32'd0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_bf     = 4'd0;
        bus.in_pred   = 1'b0;
        bus.out_ready = 1'b1;
        fork
            model_loop();
            compare_loop();
        join_none

        // Pin the reference model with hand-computed values
        e = ref_eval(32'h100, 32'd3, 32'd42, 32'd42, 4'b0010, 1'b1);
        chk("ref_beq_npc", e.npc, 32'h110);
        chk("ref_beq_mis", e.mis, 1'b0);
        e = ref_eval(32'h200, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 4'b0000, 1'b0);
        chk("ref_bltz_npc", e.npc, 32'h1FC);
        chk("ref_bltz_mis", e.mis, 1'b1);
        e = ref_eval(32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0, 4'b0001, 1'b1);
        chk("ref_wrap_npc", e.npc, 32'h0);
        e = ref_eval(32'h700, 32'd5, 32'd0, 32'd0, 4'b1010, 1'b1);
        chk("ref_illegal", {e.illegal, e.taken, e.mis}, 3'b101);
        chk("ref_illegal_npc", e.npc, 32'h704);

        // Reset state
        #3;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_redirect", {bus.redirect_valid, bus.redirect_pc}, 33'd0);
        chk("rst_counters", {bus.br_cnt, bus.mis_cnt}, 32'd0);
        chk("rst_out_npc", bus.out_npc, 32'd0);
        #4 rst_n = 1'b1;
        tick();

        // Correctly predicted BEQ: two-cycle latency
        drive(32'h100, 32'd3, 32'd42, 32'd42, 4'b0010, 1'b1);
        tick(); bus.in_valid = 1'b0;
        chk("beq_lat1_valid", bus.out_valid, 1'b0);
        tick();
        chk("beq_result", {bus.out_valid, bus.out_taken, bus.out_mispred, bus.out_npc}, {3'b110, 32'h110});
        tick();
        chk("beq_br_cnt", bus.br_cnt, 16'd1);
        chk("beq_no_redirect", bus.redirect_valid, 1'b0);

        // Mispredicted BLTZ: redirect pulse one cycle after retire
        drive(32'h200, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 4'b0000, 1'b0);
        tick(); bus.in_valid = 1'b0;
        tick();
        chk("bltz_result", {bus.out_valid, bus.out_taken, bus.out_mispred, bus.out_npc}, {3'b111, 32'h1FC});
        tick();
        chk("bltz_redirect", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h1FC});
        chk("bltz_mis_cnt", bus.mis_cnt, 16'd1);
        tick();
        chk("bltz_redirect_hold", {bus.redirect_valid, bus.redirect_pc}, {1'b0, 32'h1FC});

        // Squash of the younger op and of an op accepted in the retire cycle
        drive(32'h300, 32'd1, 32'd7, 32'd0, 4'b0101, 1'b0);
        tick();
        drive(32'h304, 32'd0, 32'd10, 32'd5, 4'b0011, 1'b0);
        tick();
        chk("bgtz_npc", {bus.out_mispred, bus.out_npc}, {1'b1, 32'h308});
        drive(32'h308, 32'd0, 32'd0, 32'd0, 4'b0110, 1'b1);
        tick(); bus.in_valid = 1'b0;
        chk("squash_redirect", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h308});
        chk("squash_cnts", {bus.br_cnt, bus.mis_cnt}, {16'd3, 16'd2});
        chk("squash_out_valid", bus.out_valid, 1'b0);
        tick();
        chk("squash_drained", {bus.out_valid, bus.redirect_valid, bus.br_cnt}, {2'b00, 16'd3});

        // Backpressure: two accepted, third held, in-order drain
        bus.out_ready = 1'b0;
        drive(32'h400, 32'd0, 32'd0, 32'd0, 4'b0110, 1'b1);
        tick();
        drive(32'h500, 32'd0, 32'd1, 32'd2, 4'b0010, 1'b0);
        tick();
        drive(32'h600, 32'd4, 32'd1, 32'd2, 4'b0011, 1'b1);
        #1 chk("bp_in_ready_low", bus.in_ready, 1'b0);
        tick();
        chk("bp_stall1", {bus.in_ready, bus.out_valid, bus.out_npc}, {2'b01, 32'h404});
        tick(); tick(); tick();
        chk("bp_stall4", {bus.out_valid, bus.out_npc, bus.br_cnt}, {1'b1, 32'h404, 16'd3});
        bus.out_ready = 1'b1;
        #1 chk("bp_in_ready_high", bus.in_ready, 1'b1);
        tick(); bus.in_valid = 1'b0;
        chk("bp_drain1", {bus.out_valid, bus.out_npc}, {1'b1, 32'h504});
        tick();
        chk("bp_drain2", {bus.out_valid, bus.out_npc}, {1'b1, 32'h614});
        tick();
        chk("bp_done", {bus.out_valid, bus.br_cnt, bus.mis_cnt}, {1'b0, 16'd6, 16'd2});

        // Illegal code with pred=1, then PC wrap
        drive(32'h700, 32'd5, 32'd0, 32'd0, 4'b1010, 1'b1);
        tick(); bus.in_valid = 1'b0;
        tick();
        chk("illegal_result", {bus.out_illegal, bus.out_taken, bus.out_mispred, bus.out_npc}, {3'b101, 32'h704});
        tick();
        chk("illegal_redirect", {bus.redirect_valid, bus.redirect_pc}, {1'b1, 32'h704});
        drive(32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0, 4'b0001, 1'b1);
        tick(); bus.in_valid = 1'b0;
        tick();
        chk("wrap_result", {bus.out_taken, bus.out_mispred, bus.out_npc}, {2'b10, 32'h0});
        tick();
        chk("wrap_cnts", {bus.br_cnt, bus.mis_cnt}, {16'd8, 16'd3});

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready = ($urandom % 4) != 0;
            if (($urandom % 3) != 0) begin
                ra = pick_operand();
                drive($urandom, (($urandom % 4) == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8,
                      ra, (($urandom % 2) == 0) ? ra : pick_operand(),
                      (($urandom % 8) == 0) ? 4'($urandom) : 4'($urandom_range(0, 6)), 1'($urandom));
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick(); tick(); tick();

        // Reset with both stages occupied and a mispredict waiting in S2
        bus.out_ready = 1'b0;
        drive(32'h800, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'b0000, 1'b0);
        tick();
        drive(32'h900, 32'd0, 32'd0, 32'd0, 4'b0110, 1'b1);
        tick(); bus.in_valid = 1'b0;
        chk("prerst_full", {bus.out_valid, bus.in_ready}, 2'b10);
        #1 rst_n = 1'b0;
        #1 chk("midrst_outputs", {bus.out_valid, bus.in_ready, bus.redirect_valid}, 3'b010);
        chk("midrst_cnts", {bus.br_cnt, bus.mis_cnt}, 32'd0);
        bus.out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_quiet", {bus.out_valid, bus.redirect_valid}, 2'b00);
        tick();
        chk("postrst_state", {bus.out_valid, bus.redirect_valid, bus.br_cnt, bus.mis_cnt}, 34'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
